// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter between the I-cache and D-cache
// line ports and the single 256-bit physical memory port.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ipmem_read/write          I-cache line request (write wins if both high)
//   ipmem_address/wdata       I-cache line address / write line
//   ipmem_resp/rdata          I-cache completion / read line
//   dpmem_*                   same set for the D-cache
//   pmem_rdata, pmem_resp     memory read line / completion
//   pmem_address/wdata        captured address / write line to memory
//   pmem_read/write           memory strobes, high for the whole transaction
//
// One transaction is in flight at a time. Address, write line and operation
// are captured at grant so memory sees stable inputs until pmem_resp.
module pmem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         ipmem_read,
  input  logic         ipmem_write,
  input  logic [31:0]  ipmem_address,
  input  logic [255:0] ipmem_wdata,
  output logic         ipmem_resp,
  output logic [255:0] ipmem_rdata,
  input  logic         dpmem_read,
  input  logic         dpmem_write,
  input  logic [31:0]  dpmem_address,
  input  logic [255:0] dpmem_wdata,
  output logic         dpmem_resp,
  output logic [255:0] dpmem_rdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]   state;
  logic         last_grant;  // 0 = I, 1 = D
  logic         op_q;        // 1 = write, 0 = read
  logic [31:0]  addr_q;
  logic [255:0] wdata_q;

  logic i_req, d_req, grant_d, busy;

  assign i_req = ipmem_read | ipmem_write;
  assign d_req = dpmem_read | dpmem_write;
  // D wins when it is alone, or when both request and I was served last.
  assign grant_d = d_req & (~i_req | ~last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            state      <= grant_d ? BUSY_D : BUSY_I;
            last_grant <= grant_d;
            // write input alone decides the op, so read+write becomes a write
            op_q       <= grant_d ? dpmem_write   : ipmem_write;
            addr_q     <= grant_d ? dpmem_address : ipmem_address;
            wdata_q    <= grant_d ? dpmem_wdata   : ipmem_wdata;
          end
        end
        BUSY_I, BUSY_D: begin
          if (pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state == BUSY_I) | (state == BUSY_D);
  assign pmem_read    = busy & ~op_q;
  assign pmem_write   = busy & op_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion is routed combinationally to the owner only; a pmem_resp
  // seen in IDLE (e.g. for a transaction killed by reset) goes nowhere.
  assign ipmem_resp  = (state == BUSY_I) & pmem_resp;
  assign dpmem_resp  = (state == BUSY_D) & pmem_resp;
  assign ipmem_rdata = pmem_rdata;
  assign dpmem_rdata = pmem_rdata;

endmodule
